// File: rtl/simon_input_loader.sv
// Host-side word loader for a SIMON block cipher: packs N-bit host words into a
// 2N-bit plaintext and an M-word key, then hands each off with a new*/ld* handshake.
module simon_input_loader #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                wrValid,
  input  logic                wrSel,
  input  logic [N-1:0]        wrData,
  output logic                rdyData,
  output logic                rdyKey,
  input  logic                flush,
  output logic [2*N-1:0]      plain,
  output logic [M-1:0][N-1:0] key,
  output logic                newData,
  output logic                newKey,
  input  logic                ldData,
  input  logic                ldKey,
  output logic                keyValid
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAITKEY = 2'd1,
    REQ     = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t                r_d_state;
  state_t                r_k_state;
  logic [0:0]            r_d_cnt;
  logic [KW-1:0]         r_k_cnt;
  logic [2*N-1:0]        r_plain;
  logic [M-1:0][N-1:0]   r_key;
  logic                  r_new_data;
  logic                  r_new_key;
  logic                  r_key_valid;

  logic                  w_acc_data;
  logic                  w_acc_key;
  logic [KW-1:0]         w_k_idx;

  assign rdyData  = (r_d_state == FILL);
  assign rdyKey   = (r_k_state == FILL);
  assign plain    = r_plain;
  assign key      = r_key;
  assign newData  = r_new_data;
  assign newKey   = r_new_key;
  assign keyValid = r_key_valid;

  assign w_acc_data = wrValid & ~wrSel & rdyData;
  assign w_acc_key  = wrValid &  wrSel & rdyKey;
  // First key word lands in the most significant slot.
  assign w_k_idx    = K_LAST - r_k_cnt;

  // Plaintext path. Only enters REQ once a key has been delivered.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_d_state  <= FILL;
      r_d_cnt    <= '0;
      r_plain    <= '0;
      r_new_data <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (r_d_state)
        FILL: begin
          if (flush) begin
            r_d_cnt <= '0;
          end else if (w_acc_data) begin
            if (r_d_cnt == 1'b0) begin
              r_plain[2*N-1:N] <= wrData;
              r_d_cnt          <= 1'b1;
            end else begin
              r_plain[N-1:0] <= wrData;
              r_d_cnt        <= '0;
              if (r_key_valid) begin
                r_d_state  <= REQ;
                r_new_data <= 1'b1;
              end else begin
                r_d_state <= WAITKEY;
              end
            end
          end
        end
        WAITKEY: begin
          if (r_key_valid) begin
            r_d_state  <= REQ;
            r_new_data <= 1'b1;
          end
        end
        REQ: begin
          if (ldData) r_d_state <= ACK;
        end
        ACK: begin
          if (!ldData) begin
            r_d_state  <= FILL;
            r_new_data <= 1'b0;
            r_d_cnt    <= '0;
          end
        end
        default: r_d_state <= FILL;
      endcase
    end
  end

  // Key path; never waits on the plaintext path.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_k_state   <= FILL;
      r_k_cnt     <= '0;
      r_key       <= '0;
      r_new_key   <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_k_state)
        FILL: begin
          if (flush) begin
            r_k_cnt <= '0;
          end else if (w_acc_key) begin
            r_key[w_k_idx] <= wrData;
            if (r_k_cnt == K_LAST) begin
              r_k_cnt   <= '0;
              r_k_state <= REQ;
              r_new_key <= 1'b1;
            end else begin
              r_k_cnt <= r_k_cnt + 1'b1;
            end
          end
        end
        REQ: begin
          if (ldKey) r_k_state <= ACK;
        end
        ACK: begin
          if (!ldKey) begin
            r_k_state   <= FILL;
            r_new_key   <= 1'b0;
            r_k_cnt     <= '0;
            r_key_valid <= 1'b1;
          end
        end
        default: r_k_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_input_loader.sv
// Self-checking bench for simon_input_loader: directed vector table, hand-written
// handshake/reset sequences, and randomized traffic against a queue-based model.
module tb_simon_input_loader;

  localparam int N = 16;
  localparam int M = 4;

  logic                clk;
  logic                nR;
  logic                wrValid;
  logic                wrSel;
  logic [N-1:0]        wrData;
  logic                rdyData;
  logic                rdyKey;
  logic                flush;
  logic [2*N-1:0]      plain;
  logic [M-1:0][N-1:0] key;
  logic                newData;
  logic                newKey;
  logic                ldData;
  logic                ldKey;
  logic                keyValid;

  int n_tests = 0;
  int n_fail  = 0;

  simon_input_loader #(.N(N), .M(M)) dut (
    .clk(clk), .nR(nR), .wrValid(wrValid), .wrSel(wrSel), .wrData(wrData),
    .rdyData(rdyData), .rdyKey(rdyKey), .flush(flush), .plain(plain), .key(key),
    .newData(newData), .newKey(newKey), .ldData(ldData), .ldKey(ldKey),
    .keyValid(keyValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic sel, input logic [N-1:0] d,
                     input logic fl, input logic ldd, input logic ldk);
    @(negedge clk);
    wrValid = v; wrSel = sel; wrData = d; flush = fl; ldData = ldd; ldKey = ldk;
    @(posedge clk);
    #1;
  endtask

  // {rdyData, rdyKey, newData, newKey, keyValid}
  function automatic logic [4:0] ctrl();
    return {rdyData, rdyKey, newData, newKey, keyValid};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, sel;
    logic [15:0] d;
    logic        fl, ldd, ldk;
    logic [4:0]  exp_ctrl;
    logic [31:0] exp_plain;
    logic [63:0] exp_key;
  } vec_t;

  localparam logic [63:0] K_FULL = 64'h1918_1110_0908_0100;

  vec_t vecs[18];

  // ---------------- reference model ----------------
  logic [15:0]    m_dq[$];
  logic [15:0]    m_kq[$];
  logic [31:0]    m_plain;
  logic [63:0]    m_key;
  bit             m_kv;
  bit             m_d_busy, m_d_hold, m_d_seen;
  bit             m_k_busy, m_k_seen;

  task automatic model_reset();
    m_dq.delete(); m_kq.delete();
    m_plain = '0; m_key = '0; m_kv = 0;
    m_d_busy = 0; m_d_hold = 0; m_d_seen = 0;
    m_k_busy = 0; m_k_seen = 0;
  endtask

  task automatic model_step(input logic v, input logic sel, input logic [15:0] d,
                            input logic fl, input logic ldd, input logic ldk);
    bit kv_old;
    int slot;
    kv_old = m_kv;
    if (!m_d_busy) begin
      if (fl) m_dq.delete();
      else if (v && !sel) begin
        if (m_dq.size() == 0) m_plain[31:16] = d;
        else                  m_plain[15:0]  = d;
        m_dq.push_back(d);
        if (m_dq.size() == 2) begin
          m_dq.delete();
          m_d_busy = 1; m_d_hold = !kv_old; m_d_seen = 0;
        end
      end
    end else if (m_d_hold) begin
      if (kv_old) m_d_hold = 0;
    end else if (!m_d_seen) begin
      if (ldd) m_d_seen = 1;
    end else if (!ldd) begin
      m_d_busy = 0;
    end

    if (!m_k_busy) begin
      if (fl) m_kq.delete();
      else if (v && sel) begin
        slot = M - 1 - m_kq.size();
        m_key[slot*16 +: 16] = d;
        m_kq.push_back(d);
        if (m_kq.size() == M) begin
          m_kq.delete();
          m_k_busy = 1; m_k_seen = 0;
        end
      end
    end else if (!m_k_seen) begin
      if (ldk) m_k_seen = 1;
    end else if (!ldk) begin
      m_k_busy = 0;
      m_kv = 1;
    end
  endtask

  function automatic logic [4:0] model_ctrl();
    return {!m_d_busy, !m_k_busy, m_d_busy && !m_d_hold, m_k_busy, m_kv};
  endfunction

  initial begin
    //            v  sel d        fl ldd ldk  ctrl     plain          key
    vecs[0]  = '{1, 0, 16'h6565, 0, 0, 0, 5'b11000, 32'h6565_0000, 64'h0};
    vecs[1]  = '{1, 0, 16'h6877, 0, 0, 0, 5'b01000, 32'h6565_6877, 64'h0};
    vecs[2]  = '{1, 1, 16'h1918, 0, 0, 0, 5'b01000, 32'h6565_6877, 64'h1918_0000_0000_0000};
    vecs[3]  = '{1, 1, 16'h1110, 0, 0, 0, 5'b01000, 32'h6565_6877, 64'h1918_1110_0000_0000};
    vecs[4]  = '{1, 1, 16'h0908, 0, 0, 0, 5'b01000, 32'h6565_6877, 64'h1918_1110_0908_0000};
    vecs[5]  = '{1, 1, 16'h0100, 0, 0, 0, 5'b00010, 32'h6565_6877, K_FULL};
    vecs[6]  = '{0, 0, 16'h0000, 0, 0, 1, 5'b00010, 32'h6565_6877, K_FULL};
    vecs[7]  = '{0, 0, 16'h0000, 0, 0, 1, 5'b00010, 32'h6565_6877, K_FULL};
    vecs[8]  = '{0, 0, 16'h0000, 0, 0, 0, 5'b01001, 32'h6565_6877, K_FULL};
    vecs[9]  = '{0, 0, 16'h0000, 0, 0, 0, 5'b01101, 32'h6565_6877, K_FULL};
    vecs[10] = '{1, 0, 16'hFFFF, 0, 1, 0, 5'b01101, 32'h6565_6877, K_FULL};
    vecs[11] = '{1, 0, 16'hEEEE, 0, 0, 0, 5'b11001, 32'h6565_6877, K_FULL};
    vecs[12] = '{1, 0, 16'hAAAA, 0, 0, 0, 5'b11001, 32'hAAAA_6877, K_FULL};
    vecs[13] = '{1, 0, 16'h5555, 1, 0, 0, 5'b11001, 32'hAAAA_6877, K_FULL};
    vecs[14] = '{1, 0, 16'h1111, 0, 0, 0, 5'b11001, 32'h1111_6877, K_FULL};
    vecs[15] = '{1, 0, 16'h2222, 0, 0, 0, 5'b01101, 32'h1111_2222, K_FULL};
    vecs[16] = '{0, 0, 16'h0000, 0, 1, 0, 5'b01101, 32'h1111_2222, K_FULL};
    vecs[17] = '{0, 0, 16'h0000, 0, 0, 0, 5'b11001, 32'h1111_2222, K_FULL};

    nR = 1'b0; wrValid = 0; wrSel = 0; wrData = '0; flush = 0; ldData = 0; ldKey = 0;
    #12;
    check("reset_ctrl",  64'(ctrl()), 64'(5'b11000));
    check("reset_plain", 64'(plain), 64'h0);
    check("reset_key",   64'(key), 64'h0);

    @(negedge clk); nR = 1'b1;
    cyc(0, 0, 16'h0, 0, 1, 1);
    check("post_release_ctrl",  64'(ctrl()), 64'(5'b11000));
    check("post_release_plain", 64'(plain), 64'h0);

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].fl, vecs[i].ldd, vecs[i].ldk);
      check($sformatf("vec%0d_ctrl", i),  64'(ctrl()), 64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_plain", i), 64'(plain), 64'(vecs[i].exp_plain));
      check($sformatf("vec%0d_key", i),   64'(key), vecs[i].exp_key);
    end

    // Overlapping requests; key path completes with ldKey already high.
    cyc(1, 0, 16'h0123, 0, 0, 0);
    cyc(1, 1, 16'hA000, 0, 0, 0);
    cyc(1, 1, 16'hA001, 0, 0, 0);
    cyc(1, 1, 16'hA002, 0, 0, 0);
    cyc(1, 0, 16'h4567, 0, 0, 0);
    check("conc_data_req", 64'(ctrl()), 64'(5'b01101));
    cyc(1, 1, 16'hA003, 0, 0, 1);
    check("conc_both_req", 64'(ctrl()), 64'(5'b00111));
    cyc(0, 0, 16'h0, 0, 0, 1);
    check("conc_key_ack", 64'(ctrl()), 64'(5'b00111));
    cyc(0, 0, 16'h0, 0, 1, 0);
    check("conc_key_done", 64'(ctrl()), 64'(5'b01101));
    cyc(0, 0, 16'h0, 0, 0, 0);
    check("conc_data_done", 64'(ctrl()), 64'(5'b11001));
    check("conc_plain", 64'(plain), 64'h0123_4567);
    check("conc_key",   64'(key), 64'hA000_A001_A002_A003);

    // Asynchronous reset while both paths sit in ACK.
    cyc(1, 0, 16'hBEEF, 0, 0, 0);
    cyc(1, 0, 16'hCAFE, 0, 0, 0);
    for (int i = 0; i < M; i++) cyc(1, 1, 16'(i + 16'h7000), 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 1, 1);
    check("pre_reset_ack", 64'(ctrl()), 64'(5'b00111));
    @(negedge clk); #2;
    nR = 1'b0;
    #1;
    check("async_rst_ctrl",  64'(ctrl()), 64'(5'b11000));
    check("async_rst_plain", 64'(plain), 64'h0);
    check("async_rst_key",   64'(key), 64'h0);
    wrValid = 0; ldData = 0; ldKey = 0; flush = 0;

    // Randomized traffic against the reference model.
    model_reset();
    @(negedge clk); nR = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic v, sel, fl, ldd, ldk;
      logic [15:0] d;
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 1);
      d   = 16'($urandom);
      fl  = ($urandom_range(0, 11) == 0);
      ldd = ($urandom_range(0, 2) != 0);
      ldk = ($urandom_range(0, 2) != 0);
      cyc(v, sel, d, fl, ldd, ldk);
      model_step(v, sel, d, fl, ldd, ldk);
      check($sformatf("rand%0d_ctrl", c),  64'(ctrl()), 64'(model_ctrl()));
      check($sformatf("rand%0d_plain", c), 64'(plain), 64'(m_plain));
      check($sformatf("rand%0d_key", c),   64'(key), m_key);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
